// File: rtl/aidc_lite_comp_dispatch.sv
//------------------------------------------------------------------------------
// aidc_lite_comp_dispatch
//
// Takes the compressor job programmed through the config register file
// (source, destination, length in 128-byte blocks, start pulse) and issues it
// to the datapath. The job is split into fixed-size blocks: one read command
// per block goes to the read engine, then one write command per block goes to
// the write engine, in the same order. Write completions are counted, and
// once every block has completed the job-done level is raised back to the
// register file.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   src_addr_i       job source byte address (block aligned)
//   dst_addr_i       job destination byte address (block aligned)
//   len_i            job length in blocks
//   start_i          one-cycle start pulse; only honoured while idle
//   done_o           level: job complete, cleared by an accepted start
//   busy_o           high while a job is in progress
//   rd_cmd_*         valid/ready read command channel, block address
//   wr_cmd_*         valid/ready write command channel, block address
//   wr_cpl_i         one-cycle pulse per fully written block
//   err_o            sticky: completion seen with nothing outstanding
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module aidc_lite_comp_dispatch #(
   parameter int unsigned MAX_OUTSTANDING = 8,
   parameter int unsigned BLK_BYTES       = 128
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] src_addr_i,
   input  logic [31:0] dst_addr_i,
   input  logic [24:0] len_i,
   input  logic        start_i,
   output logic        done_o,
   output logic        busy_o,
   output logic        rd_cmd_valid_o,
   input  logic        rd_cmd_ready_i,
   output logic [31:0] rd_cmd_addr_o,
   output logic        wr_cmd_valid_o,
   input  logic        wr_cmd_ready_i,
   output logic [31:0] wr_cmd_addr_o,
   input  logic        wr_cpl_i,
   output logic        err_o
);

   localparam int unsigned BLK_SHIFT = $clog2(BLK_BYTES);
   localparam int unsigned OW        = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);
   localparam logic [OW-1:0] OUT_ONE = OW'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t        state, state_nxt;
   logic [31:0]   src_q, src_nxt;
   logic [31:0]   dst_q, dst_nxt;
   logic [24:0]   blk_cnt, blk_cnt_nxt;
   logic [24:0]   rd_idx, rd_idx_nxt;
   logic [24:0]   wr_idx, wr_idx_nxt;
   logic [24:0]   cpl_idx, cpl_idx_nxt;
   logic [OW-1:0] outst, outst_nxt;
   logic          done_q, done_nxt;
   logic          err_q, err_nxt;

   logic          rd_fire;
   logic          wr_fire;
   logic          cpl_ok;

   // Valids depend only on registered state. The read valid can only fall
   // through rd_idx or outst rising, and both rise only on a read handshake;
   // the write valid can only fall through wr_idx rising. So neither valid
   // nor its address can change while a command is stalled.
   always_comb begin
      rd_cmd_valid_o = (state == RUN) && (rd_idx < blk_cnt) && (outst < OUT_MAX);
      wr_cmd_valid_o = (state == RUN) && (wr_idx < rd_idx);
      rd_cmd_addr_o  = src_q + (32'(rd_idx) << BLK_SHIFT);
      wr_cmd_addr_o  = dst_q + (32'(wr_idx) << BLK_SHIFT);
      busy_o         = (state != IDLE);
      done_o         = done_q;
      err_o          = err_q;
   end

   assign rd_fire = rd_cmd_valid_o & rd_cmd_ready_i;
   assign wr_fire = wr_cmd_valid_o & wr_cmd_ready_i;
   assign cpl_ok  = wr_cpl_i & (outst != '0);

   always_comb begin
      state_nxt   = state;
      src_nxt     = src_q;
      dst_nxt     = dst_q;
      blk_cnt_nxt = blk_cnt;
      rd_idx_nxt  = rd_idx;
      wr_idx_nxt  = wr_idx;
      cpl_idx_nxt = cpl_idx;
      outst_nxt   = outst;
      done_nxt    = done_q;
      err_nxt     = err_q;

      if (rd_fire) rd_idx_nxt = rd_idx + 25'd1;
      if (wr_fire) wr_idx_nxt = wr_idx + 25'd1;
      if (cpl_ok)  cpl_idx_nxt = cpl_idx + 25'd1;

      // Read accept and completion in the same cycle cancel out.
      case ({rd_fire, cpl_ok})
         2'b10:   outst_nxt = outst + OUT_ONE;
         2'b01:   outst_nxt = outst - OUT_ONE;
         default: outst_nxt = outst;
      endcase

      if (wr_cpl_i && (outst == '0)) err_nxt = 1'b1;

      case (state)
         IDLE: begin
            // An accepted start overrides any stray completion this cycle.
            if (start_i) begin
               src_nxt     = src_addr_i;
               dst_nxt     = dst_addr_i;
               blk_cnt_nxt = len_i;
               rd_idx_nxt  = '0;
               wr_idx_nxt  = '0;
               cpl_idx_nxt = '0;
               outst_nxt   = '0;
               err_nxt     = 1'b0;
               if (len_i == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  done_nxt  = 1'b0;
                  state_nxt = RUN;
               end
            end
         end
         RUN: begin
            // Completions could in principle all land by the last write
            // handshake; finish directly rather than parking in DRAIN.
            if ((rd_idx_nxt == blk_cnt) && (wr_idx_nxt == blk_cnt)) begin
               if (cpl_idx_nxt == blk_cnt) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (cpl_idx_nxt == blk_cnt) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         blk_cnt <= '0;
         rd_idx  <= '0;
         wr_idx  <= '0;
         cpl_idx <= '0;
         outst   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         src_q   <= src_nxt;
         dst_q   <= dst_nxt;
         blk_cnt <= blk_cnt_nxt;
         rd_idx  <= rd_idx_nxt;
         wr_idx  <= wr_idx_nxt;
         cpl_idx <= cpl_idx_nxt;
         outst   <= outst_nxt;
         done_q  <= done_nxt;
         err_q   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_aidc_lite_comp_dispatch.sv
//------------------------------------------------------------------------------
// Directed bench for aidc_lite_comp_dispatch. Inputs change and outputs are
// sampled 1 ns after each rising edge; handshakes are logged at the edge.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_aidc_lite_comp_dispatch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [24:0] len;
   logic        start;
   logic        done;
   logic        busy;
   logic        rd_v;
   logic        rd_r;
   logic [31:0] rd_addr;
   logic        wr_v;
   logic        wr_r;
   logic [31:0] wr_addr;
   logic        wr_cpl;
   logic        err;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] rd_q[$];
   logic [31:0] wr_q[$];
   logic        auto_cpl = 1'b0;
   logic        cpl_man  = 1'b0;
   logic [1:0]  cpl_pipe = '0;

   always #5 clk = ~clk;

   aidc_lite_comp_dispatch #(.MAX_OUTSTANDING(8), .BLK_BYTES(128)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .src_addr_i     (src_addr),
      .dst_addr_i     (dst_addr),
      .len_i          (len),
      .start_i        (start),
      .done_o         (done),
      .busy_o         (busy),
      .rd_cmd_valid_o (rd_v),
      .rd_cmd_ready_i (rd_r),
      .rd_cmd_addr_o  (rd_addr),
      .wr_cmd_valid_o (wr_v),
      .wr_cmd_ready_i (wr_r),
      .wr_cmd_addr_o  (wr_addr),
      .wr_cpl_i       (wr_cpl),
      .err_o          (err)
   );

   // Completion model: a pulse two cycles after each accepted write.
   always @(posedge clk) begin
      if (!rst_n) cpl_pipe <= '0;
      else        cpl_pipe <= {cpl_pipe[0], auto_cpl & wr_v & wr_r};
   end
   assign wr_cpl = cpl_man | cpl_pipe[1];

   always @(posedge clk) begin
      if (rst_n && rd_v && rd_r) rd_q.push_back(rd_addr);
      if (rst_n && wr_v && wr_r) wr_q.push_back(wr_addr);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (done !== 1'b1 && k < 80) begin
         tick();
         k++;
      end
      check(tag, {31'd0, done}, 32'd1);
   endtask

   task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [24:0] l);
      src_addr = s;
      dst_addr = d;
      len      = l;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   initial begin
      logic [9:0]  pat;
      logic        pv, pwv;
      logic [31:0] pa;
      int          ncpl;

      rst_n = 1'b0; src_addr = '0; dst_addr = '0; len = '0; start = 1'b0;
      rd_r = 1'b0; wr_r = 1'b0;
      repeat (3) tick();

      // reset state
      check("rst_done",  {31'd0, done}, 32'd0);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_err",   {31'd0, err},  32'd0);
      check("rst_rdv",   {31'd0, rd_v}, 32'd0);
      check("rst_wrv",   {31'd0, wr_v}, 32'd0);
      check("rst_rdadr", rd_addr, 32'h0);
      check("rst_wradr", wr_addr, 32'h0);
      rst_n = 1'b1;
      tick();

      // 1: zero-length job
      rd_q.delete(); wr_q.delete();
      rd_r = 1'b1; wr_r = 1'b1;
      pulse_start(32'h0, 32'h0, 25'd0);
      check("t1_done", {31'd0, done}, 32'd1);
      check("t1_busy", {31'd0, busy}, 32'd0);
      check("t1_rdv",  {31'd0, rd_v}, 32'd0);
      repeat (3) tick();
      check("t1_busy2", {31'd0, busy}, 32'd0);
      check("t1_nocmd", rd_q.size() + wr_q.size(), 32'd0);

      // 2: three-block job, completions two cycles after each write
      rd_q.delete(); wr_q.delete();
      auto_cpl = 1'b1;
      pulse_start(32'h1000, 32'h8000, 25'd3);
      check("t2_done0", {31'd0, done}, 32'd0);
      check("t2_busy",  {31'd0, busy}, 32'd1);
      check("t2_rdv",   {31'd0, rd_v}, 32'd1);
      check("t2_rdadr", rd_addr, 32'h1000);
      ncpl = 0;
      for (int k = 0; k < 40 && ncpl < 3; k++) begin
         tick();
         if (wr_cpl) ncpl++;
      end
      check("t2_ncpl", ncpl, 32'd3);
      check("t2_notyet", {31'd0, done}, 32'd0);
      tick();
      check("t2_done", {31'd0, done}, 32'd1);
      check("t2_idle", {31'd0, busy}, 32'd0);
      check("t2_nrd", rd_q.size(), 32'd3);
      check("t2_nwr", wr_q.size(), 32'd3);
      check("t2_rd0", rd_q[0], 32'h1000);
      check("t2_rd1", rd_q[1], 32'h1080);
      check("t2_rd2", rd_q[2], 32'h1100);
      check("t2_wr0", wr_q[0], 32'h8000);
      check("t2_wr1", wr_q[1], 32'h8080);
      check("t2_wr2", wr_q[2], 32'h8100);
      check("t2_err", {31'd0, err}, 32'd0);

      // 3: outstanding limit with completions withheld
      rd_q.delete(); wr_q.delete();
      auto_cpl = 1'b0;
      pulse_start(32'h0, 32'h10000, 25'd20);
      repeat (15) tick();
      check("t3_nrd8", rd_q.size(), 32'd8);
      check("t3_rdv0", {31'd0, rd_v}, 32'd0);
      cpl_man = 1'b1;
      tick();
      cpl_man = 1'b0;
      check("t3_rdv1", {31'd0, rd_v}, 32'd1);
      tick();
      check("t3_nrd9", rd_q.size(), 32'd9);
      check("t3_rdv2", {31'd0, rd_v}, 32'd0);
      for (int k = 0; k < 19; k++) begin
         cpl_man = 1'b1;
         tick();
      end
      cpl_man = 1'b0;
      check("t3_done", {31'd0, done}, 32'd1);
      check("t3_err",  {31'd0, err},  32'd0);
      check("t3_nrd",  rd_q.size(), 32'd20);
      check("t3_nwr",  wr_q.size(), 32'd20);
      check("t3_rd19", rd_q[19], 32'h980);

      // 4: stalled channels keep valid/addr; write order follows read order
      rd_q.delete(); wr_q.delete();
      auto_cpl = 1'b1;
      rd_r = 1'b0; wr_r = 1'b0;
      pat  = 10'b0110100110;
      pulse_start(32'h2000, 32'h9000, 25'd4);
      for (int i = 0; i < 10; i++) begin
         rd_r = pat[i];
         pv   = rd_v;
         pa   = rd_addr;
         pwv  = wr_v;
         tick();
         if (pv && !pat[i]) begin
            check("t4_rdv_hold", {31'd0, rd_v}, 32'd1);
            check("t4_rda_hold", rd_addr, pa);
         end
         if (pwv) check("t4_wrv_hold", {31'd0, wr_v}, 32'd1);
      end
      check("t4_wrv", {31'd0, wr_v}, 32'd1);
      check("t4_wra", wr_addr, 32'h9000);
      rd_r = 1'b1; wr_r = 1'b1;
      wait_done("t4_timeout");
      check("t4_nrd", rd_q.size(), 32'd4);
      check("t4_nwr", wr_q.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("t4_rd_ord", rd_q[i], 32'h2000 + 32'(i) * 32'd128);
         check("t4_wr_ord", wr_q[i], 32'h9000 + 32'(i) * 32'd128);
      end

      // 5: address wrap, ignored restart, spurious completion
      rd_q.delete(); wr_q.delete();
      pulse_start(32'hFFFF_FF80, 32'h0, 25'd2);
      tick();
      pulse_start(32'h5000, 32'h7000, 25'd9);
      wait_done("t5_timeout");
      check("t5_nrd", rd_q.size(), 32'd2);
      check("t5_rd0", rd_q[0], 32'hFFFF_FF80);
      check("t5_rd1", rd_q[1], 32'h0000_0000);
      check("t5_wr1", wr_q[1], 32'h0000_0080);
      check("t5_err0", {31'd0, err}, 32'd0);
      cpl_man = 1'b1;
      tick();
      cpl_man = 1'b0;
      check("t5_err1", {31'd0, err}, 32'd1);
      check("t5_busy", {31'd0, busy}, 32'd0);
      pulse_start(32'h0, 32'h0, 25'd0);
      check("t5_errclr", {31'd0, err}, 32'd0);
      check("t5_done",   {31'd0, done}, 32'd1);

      // 6: reset in the middle of a job, then a fresh one-block job
      rd_q.delete(); wr_q.delete();
      auto_cpl = 1'b0;
      wr_r = 1'b0;
      pulse_start(32'h3000, 32'hB000, 25'd5);
      tick();
      tick();
      check("t6_nrd2", rd_q.size(), 32'd2);
      rst_n = 1'b0;
      tick();
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_done", {31'd0, done}, 32'd0);
      check("t6_rdv",  {31'd0, rd_v}, 32'd0);
      check("t6_wrv",  {31'd0, wr_v}, 32'd0);
      check("t6_rda",  rd_addr, 32'h0);
      check("t6_wra",  wr_addr, 32'h0);
      rst_n = 1'b1;
      wr_r  = 1'b1;
      auto_cpl = 1'b1;
      tick();
      rd_q.delete(); wr_q.delete();
      pulse_start(32'h4000, 32'hA000, 25'd1);
      wait_done("t6_timeout");
      check("t6_nrd", rd_q.size(), 32'd1);
      check("t6_rd0", rd_q[0], 32'h4000);
      check("t6_wr0", wr_q[0], 32'hA000);
      check("t6_err", {31'd0, err}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
